// File: rtl/issue_scoreboard.sv
// Dual-issue RAW/WAW hazard scoreboard between decode and regfile stage.
// Optional perf counters under `ISSUE_SB_PERF_EN.
module issue_scoreboard #(
  parameter int unsigned LAT_ALU = 3,
  parameter int unsigned LAT_MEM = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        stall_in,
  input  logic        inst0_valid,
  input  logic [4:0]  inst0_rd,
  input  logic [4:0]  inst0_rj,
  input  logic [4:0]  inst0_rk,
  input  logic        inst0_rj_use,
  input  logic        inst0_rk_use,
  input  logic        inst0_rd_we,
  input  logic [2:0]  inst0_type,
  input  logic        inst1_valid,
  input  logic [4:0]  inst1_rd,
  input  logic [4:0]  inst1_rj,
  input  logic [4:0]  inst1_rk,
  input  logic        inst1_rj_use,
  input  logic        inst1_rk_use,
  input  logic        inst1_rd_we,
  input  logic [2:0]  inst1_type,
  input  logic        muldiv_done,
  input  logic [4:0]  muldiv_rd,
  output logic        issue0,
  output logic        issue1,
  output logic        raw_stall,
  output logic [31:0] busy_mask,
  output logic        md_pending
`ifdef ISSUE_SB_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_dual_cnt
`endif
);

  localparam logic [1:0] LA = 2'(LAT_ALU);
  localparam logic [1:0] LM = 2'(LAT_MEM);

  logic [31:0][1:0] cnt_q, cnt_d;
  logic [31:0]      div_q, div_d;
  logic [31:0]      pend, busy_q, busy_d;
  logic             md_q, md_d, raw_q, raw_d;
  logic             md0, priv0, mem0, alu1;
  logic             wr0, wr1, ok0, ok1, dep1;
  logic [1:0]       lat0;

  assign md0   = (inst0_type == 3'd3);
  assign priv0 = (inst0_type >= 3'd4);
  assign mem0  = (inst0_type == 3'd2);
  assign alu1  = (inst1_type == 3'd0);
  assign wr0   = inst0_rd_we & (inst0_rd != 5'd0);
  assign wr1   = inst1_rd_we & (inst1_rd != 5'd0);
  assign lat0  = mem0 ? LM : LA;

  // pending view of the current state; r0 is never tracked
  always_comb begin
    pend = '0;
    for (int r = 1; r < 32; r++)
      pend[r] = (cnt_q[r] != 2'd0) | div_q[r];
  end

  // issue decision for both slots
  always_comb begin
    ok0 = ~(inst0_rj_use & pend[inst0_rj])
        & ~(inst0_rk_use & pend[inst0_rk])
        & ~(wr0 & div_q[inst0_rd])
        & ~(md0 & md_q);
    dep1 = wr0 & ((inst1_rj_use & (inst1_rj == inst0_rd))
                | (inst1_rk_use & (inst1_rk == inst0_rd)));
    ok1 = ~(inst1_rj_use & pend[inst1_rj])
        & ~(inst1_rk_use & pend[inst1_rk])
        & ~(wr1 & div_q[inst1_rd])
        & ~dep1;
    issue0 = rstn & inst0_valid & ~stall_in & ~flush & ok0;
    issue1 = issue0 & inst1_valid & alu1
           & ~priv0 & ~md0 & ok1;
    raw_d  = inst0_valid & ~issue0 & ~stall_in & ~flush;
  end

  // next-state for counters, div_busy and md_pending
  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    md_d  = md_q;
    if (flush) begin
      cnt_d = '0;
      div_d = '0;
      md_d  = 1'b0;
    end else begin
      if (muldiv_done) begin
        div_d[muldiv_rd] = 1'b0;
        md_d = 1'b0;
      end
      if (!stall_in) begin
        for (int r = 1; r < 32; r++)
          if (cnt_q[r] != 2'd0)
            cnt_d[r] = cnt_q[r] - 2'd1;
        if (issue0 && md0) begin
          md_d = 1'b1;
          if (wr0) div_d[inst0_rd] = 1'b1;
        end else if (issue0 && wr0) begin
          cnt_d[inst0_rd] = lat0;
        end
        if (issue1 && wr1) begin
          if (!(wr0 && inst0_rd == inst1_rd
                && lat0 > LA))
            cnt_d[inst1_rd] = LA;
        end
      end
    end
    cnt_d[0] = 2'd0;
    div_d[0] = 1'b0;
    busy_d = '0;
    for (int r = 1; r < 32; r++)
      busy_d[r] = (cnt_d[r] != 2'd0) | div_d[r];
  end

  // state registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q  <= '0;
      div_q  <= '0;
      md_q   <= 1'b0;
      busy_q <= '0;
      raw_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      md_q   <= md_d;
      busy_q <= busy_d;
      raw_q  <= raw_d;
    end
  end

  assign raw_stall  = raw_q;
  assign busy_mask  = busy_q;
  assign md_pending = md_q;

`ifdef ISSUE_SB_PERF_EN
  logic [31:0] pstall_q, pdual_q;

  // stall and dual-issue event counters; survive flush
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pstall_q <= '0;
      pdual_q  <= '0;
    end else begin
      if (raw_q)  pstall_q <= pstall_q + 32'd1;
      if (issue1) pdual_q  <= pdual_q + 32'd1;
    end
  end

  assign perf_stall_cnt = pstall_q;
  assign perf_dual_cnt  = pdual_q;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized scoreboard bench for issue_scoreboard.
// Model tracks per-register ready times in active-cycle units.
module tb_issue_scoreboard;
  localparam int LAT_ALU = 3;
  localparam int LAT_MEM = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0, stall_in = 1'b0;
  logic inst0_valid = 1'b0, inst1_valid = 1'b0;
  logic [4:0] inst0_rd = '0, inst0_rj = '0, inst0_rk = '0;
  logic [4:0] inst1_rd = '0, inst1_rj = '0, inst1_rk = '0;
  logic inst0_rj_use = 1'b0, inst0_rk_use = 1'b0;
  logic inst0_rd_we = 1'b0;
  logic inst1_rj_use = 1'b0, inst1_rk_use = 1'b0;
  logic inst1_rd_we = 1'b0;
  logic [2:0] inst0_type = '0, inst1_type = '0;
  logic muldiv_done = 1'b0;
  logic [4:0] muldiv_rd = '0;
  logic issue0, issue1, raw_stall, md_pending;
  logic [31:0] busy_mask;
`ifdef ISSUE_SB_PERF_EN
  logic [31:0] perf_stall_cnt, perf_dual_cnt;
`endif

  always #5 clk = ~clk;

  issue_scoreboard #(
    .LAT_ALU(LAT_ALU), .LAT_MEM(LAT_MEM)
  ) dut (
    .clk(clk), .rstn(rstn),
    .flush(flush), .stall_in(stall_in),
    .inst0_valid(inst0_valid), .inst0_rd(inst0_rd),
    .inst0_rj(inst0_rj), .inst0_rk(inst0_rk),
    .inst0_rj_use(inst0_rj_use),
    .inst0_rk_use(inst0_rk_use),
    .inst0_rd_we(inst0_rd_we), .inst0_type(inst0_type),
    .inst1_valid(inst1_valid), .inst1_rd(inst1_rd),
    .inst1_rj(inst1_rj), .inst1_rk(inst1_rk),
    .inst1_rj_use(inst1_rj_use),
    .inst1_rk_use(inst1_rk_use),
    .inst1_rd_we(inst1_rd_we), .inst1_type(inst1_type),
    .muldiv_done(muldiv_done), .muldiv_rd(muldiv_rd),
    .issue0(issue0), .issue1(issue1),
    .raw_stall(raw_stall), .busy_mask(busy_mask),
    .md_pending(md_pending)
`ifdef ISSUE_SB_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_dual_cnt(perf_dual_cnt)
`endif
  );

  typedef struct {
    logic v, we, ju, ku;
    logic [4:0] rd, rj, rk;
    logic [2:0] ty;
  } ins_t;

  typedef struct {
    logic i0, i1, raw, mdp;
    logic [31:0] busy, ps, pd;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  int act = 0;
  int ready[32];
  bit divb[32];
  bit mdp = 0;
  bit m_raw = 0;
  logic [31:0] m_busy = '0;
  logic [31:0] m_ps = '0, m_pd = '0;
  int md_rd = 0;

  function automatic bit pend(int r);
    return r != 0 && (act < ready[r] || divb[r]);
  endfunction

  function automatic ins_t mk(logic v, logic [2:0] ty,
      logic [4:0] rd, logic we, logic [4:0] rj, logic ju,
      logic [4:0] rk, logic ku);
    ins_t i;
    i.v = v; i.ty = ty; i.rd = rd; i.we = we;
    i.rj = rj; i.ju = ju; i.rk = rk; i.ku = ku;
    return i;
  endfunction

  function automatic ins_t rnd();
    ins_t i;
    int t;
    i.v  = ($urandom_range(0, 7) != 0);
    i.rd = 5'($urandom_range(0, 7));
    i.rj = 5'($urandom_range(0, 7));
    i.rk = 5'($urandom_range(0, 7));
    i.ju = 1'($urandom);
    i.ku = 1'($urandom);
    i.we = ($urandom_range(0, 3) != 0);
    t = $urandom_range(0, 15);
    i.ty = (t < 8) ? 3'd0 : 3'(t - 8);
    if (i.ty == 3'd3) begin
      i.we = 1'b1;
      i.rd = 5'($urandom_range(1, 7));
    end
    return i;
  endfunction

  function automatic bit srcs_ok(ins_t i);
    return !(i.ju && pend(i.rj)) && !(i.ku && pend(i.rk));
  endfunction

  task automatic step(input ins_t a, input ins_t b,
      input logic fl, input logic st, input logic dn,
      input logic [4:0] drd, input logic rs);
    bit e0, e1, w0, w1, s0set;
    int nr;
    exp_t e;
    @(posedge clk); #1;
    rstn = rs; flush = fl; stall_in = st;
    muldiv_done = dn; muldiv_rd = drd;
    inst0_valid = a.v; inst0_rd = a.rd; inst0_rj = a.rj;
    inst0_rk = a.rk; inst0_rj_use = a.ju;
    inst0_rk_use = a.ku; inst0_rd_we = a.we;
    inst0_type = a.ty;
    inst1_valid = b.v; inst1_rd = b.rd; inst1_rj = b.rj;
    inst1_rk = b.rk; inst1_rj_use = b.ju;
    inst1_rk_use = b.ku; inst1_rd_we = b.we;
    inst1_type = b.ty;
    w0 = a.we && a.rd != 0;
    w1 = b.we && b.rd != 0;
    e0 = rs && a.v && !st && !fl && srcs_ok(a)
      && !(w0 && divb[a.rd]) && !(a.ty == 3 && mdp);
    e1 = e0 && b.v && b.ty == 0 && a.ty < 3 && srcs_ok(b)
      && !(w1 && divb[b.rd])
      && !(w0 && b.ju && b.rj == a.rd)
      && !(w0 && b.ku && b.rk == a.rd);
    e.i0 = e0; e.i1 = e1; e.raw = m_raw; e.mdp = mdp;
    e.busy = m_busy; e.ps = m_ps; e.pd = m_pd;
    q.push_back(e);
    if (!rs) begin
      act = 0; mdp = 0; m_raw = 0; m_busy = '0;
      m_ps = '0; m_pd = '0;
      for (int r = 0; r < 32; r++) begin
        ready[r] = 0; divb[r] = 0;
      end
    end else begin
      if (m_raw) m_ps = m_ps + 1;
      if (e1) m_pd = m_pd + 1;
      m_raw = a.v && !e0 && !st && !fl;
      if (fl) begin
        mdp = 0;
        for (int r = 0; r < 32; r++) begin
          ready[r] = 0; divb[r] = 0;
        end
      end else begin
        if (dn) begin divb[drd] = 0; mdp = 0; end
        if (!st) begin
          s0set = 0;
          if (e0 && a.ty == 3) begin
            mdp = 1;
            if (w0) begin divb[a.rd] = 1; md_rd = a.rd; end
          end else if (e0 && w0) begin
            ready[a.rd] = act + 1
              + (a.ty == 2 ? LAT_MEM : LAT_ALU);
            s0set = 1;
          end
          if (e1 && w1) begin
            nr = act + 1 + LAT_ALU;
            if (s0set && a.rd == b.rd && ready[b.rd] > nr)
              nr = ready[b.rd];
            ready[b.rd] = nr;
          end
          act++;
        end
      end
      m_busy = '0;
      for (int r = 1; r < 32; r++) m_busy[r] = pend(r);
    end
  endtask

  task automatic chk(input string n,
      input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t",
        n, got, exp, $time);
    end
  endtask

  // monitor: compare each cycle's outputs against the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("issue0", 32'(issue0), 32'(e.i0));
        chk("issue1", 32'(issue1), 32'(e.i1));
        chk("raw_stall", 32'(raw_stall), 32'(e.raw));
        chk("busy_mask", busy_mask, e.busy);
        chk("md_pending", 32'(md_pending), 32'(e.mdp));
`ifdef ISSUE_SB_PERF_EN
        chk("perf_stall", perf_stall_cnt, e.ps);
        chk("perf_dual", perf_dual_cnt, e.pd);
`endif
      end
    end
  end

  initial begin
    ins_t n, a, b;
    logic fl, st, dn;
    logic [4:0] drd;
    n = mk(0, 0, 0, 0, 0, 0, 0, 0);
    a = mk(1, 0, 1, 1, 2, 1, 0, 0);
    step(a, n, 0, 0, 0, 0, 0);
    step(a, n, 0, 0, 0, 0, 0);
    step(a, n, 0, 0, 0, 0, 1);
    step(mk(1, 0, 5, 1, 0, 0, 0, 0), n, 0, 0, 0, 0, 1);
    a = mk(1, 0, 6, 1, 5, 1, 0, 0);
    repeat (4) step(a, n, 0, 0, 0, 0, 1);
    repeat (4) step(n, n, 0, 0, 0, 0, 1);
    step(mk(1, 0, 3, 1, 0, 0, 0, 0),
         mk(1, 0, 8, 1, 4, 1, 0, 0), 0, 0, 0, 0, 1);
    repeat (4) step(n, n, 0, 0, 0, 0, 1);
    step(mk(1, 0, 3, 1, 0, 0, 0, 0),
         mk(1, 0, 8, 1, 3, 1, 0, 0), 0, 0, 0, 0, 1);
    repeat (4) step(n, n, 0, 0, 0, 0, 1);
    step(mk(1, 0, 3, 1, 0, 0, 0, 0),
         mk(1, 2, 8, 1, 4, 1, 0, 0), 0, 0, 0, 0, 1);
    repeat (4) step(n, n, 0, 0, 0, 0, 1);
    step(mk(1, 3, 7, 1, 1, 1, 0, 0), n, 0, 0, 0, 0, 1);
    step(mk(1, 3, 9, 1, 0, 0, 0, 0), n, 0, 0, 0, 0, 1);
    step(mk(1, 0, 7, 1, 0, 0, 0, 0), n, 0, 0, 0, 0, 1);
    step(n, n, 0, 0, 1, 7, 1);
    step(mk(1, 3, 9, 1, 0, 0, 0, 0), n, 0, 0, 0, 0, 1);
    step(mk(1, 0, 7, 1, 0, 0, 0, 0), n, 0, 0, 1, 9, 1);
    repeat (4) step(n, n, 0, 0, 0, 0, 1);
    step(mk(1, 0, 5, 1, 0, 0, 0, 0), n, 0, 0, 0, 0, 1);
    step(mk(1, 3, 10, 1, 0, 0, 0, 0), n, 0, 0, 0, 0, 1);
    a = mk(1, 0, 6, 1, 5, 1, 0, 0);
    repeat (5) step(a, n, 0, 1, 0, 0, 1);
    step(a, n, 1, 0, 0, 0, 1);
    step(a, n, 0, 0, 0, 0, 1);
    step(mk(1, 0, 0, 1, 0, 0, 0, 0), n, 0, 0, 0, 0, 1);
    step(mk(1, 0, 4, 1, 0, 1, 0, 1), n, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2000; i++) begin
      a = rnd();
      b = rnd();
      fl = ($urandom_range(0, 31) == 0);
      st = ($urandom_range(0, 7) == 0);
      dn = mdp && ($urandom_range(0, 3) == 0);
      drd = ($urandom_range(0, 7) == 0)
          ? 5'($urandom_range(0, 7)) : 5'(md_rd);
      step(a, b, fl, st, dn, drd,
           ($urandom_range(0, 299) != 0));
    end
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end
endmodule
